// File: rtl/interlaced_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : interlaced_buffer_reader
// Purpose  : Read-side scanner for the 1-bit interlaced frame buffer. Turns
//            VGA timing into upscaled buffer read addresses, maps the returned
//            pixel to RGB444 and delays sync/blank to stay aligned with it.
// Revision : 1.0 - initial release
// ============================================================================
module interlaced_buffer_reader #(
  parameter int          FRAME_W      = 320,
  parameter int          FRAME_H      = 240,
  parameter int          SCALE_LOG2   = 1,
  parameter int          READ_LATENCY = 2,     // must be >= 1
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        buf_ready,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [16:0] read_addr,
  output logic        reading,
  input  logic        buf_pixel,
  output logic [11:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_done
);

  // Address register plus buffer read latency.
  localparam int          PIPE     = 1 + READ_LATENCY;
  localparam logic [10:0] WIN_W    = 11'(FRAME_W << SCALE_LOG2);
  localparam logic [9:0]  WIN_H    = 10'(FRAME_H << SCALE_LOG2);
  localparam logic [16:0] ROW_STEP = 17'(FRAME_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              reading_q, reading_d;
  logic              frame_done_q, frame_done_d;
  logic [16:0]       read_addr_q, read_addr_d;
  logic [16:0]       row_base_q, row_base_d;
  logic [9:0]        src_row_q, src_row_d;
  logic [PIPE-1:0]   hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0]   vs_pipe_q, vs_pipe_d;
  logic [PIPE-1:0]   bl_pipe_q, bl_pipe_d;
  logic [PIPE-1:0]   act_pipe_q, act_pipe_d;

  logic              w_origin;
  logic              w_in_window;
  logic              w_last;
  logic              w_issue;
  logic [9:0]        w_src_row;
  logic [10:0]       w_src_col;
  logic [16:0]       w_base;

  assign w_origin    = (hcount == 11'd0) && (vcount == 10'd0);
  assign w_in_window = (hcount < WIN_W) && (vcount < WIN_H);
  assign w_last      = (hcount == WIN_W - 11'd1) && (vcount == WIN_H - 10'd1);
  assign w_src_row   = vcount >> SCALE_LOG2;
  assign w_src_col   = hcount >> SCALE_LOG2;

  // Next-state: arm on buf_ready, start only at frame origin, leave only at frame end.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    w_issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (buf_ready) state_d = S_ARM;
      end
      S_ARM: begin
        if (w_origin) begin
          state_d = S_SCAN;
          w_issue = 1'b1;
        end
      end
      S_SCAN: begin
        w_issue = 1'b1;
        if (w_last) begin
          frame_done_d = 1'b1;
          if (!buf_ready) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    reading_d = w_issue;
  end

  // Incremental address: row base steps by one source line when the source row advances.
  always_comb begin
    read_addr_d = read_addr_q;
    row_base_d  = row_base_q;
    src_row_d   = src_row_q;
    w_base      = row_base_q;
    if (w_issue && w_in_window) begin
      if (w_src_row == 10'd0) begin
        w_base = 17'd0;
      end else if (w_src_row != src_row_q) begin
        w_base = row_base_q + ROW_STEP;
      end
      row_base_d  = w_base;
      src_row_d   = w_src_row;
      read_addr_d = w_base + 17'(w_src_col);
    end
  end

  // Delay lines for sync/blank and the "pixel was really fetched" flag.
  always_comb begin
    hs_pipe_d  = (hs_pipe_q  << 1) | PIPE'(hsync_in);
    vs_pipe_d  = (vs_pipe_q  << 1) | PIPE'(vsync_in);
    bl_pipe_d  = (bl_pipe_q  << 1) | PIPE'(blank_in);
    act_pipe_d = (act_pipe_q << 1) | PIPE'(w_issue & w_in_window);
  end

  // State, address and delay-line registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      reading_q    <= 1'b0;
      frame_done_q <= 1'b0;
      read_addr_q  <= 17'd0;
      row_base_q   <= 17'd0;
      src_row_q    <= 10'd0;
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      bl_pipe_q    <= '0;
      act_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      reading_q    <= reading_d;
      frame_done_q <= frame_done_d;
      read_addr_q  <= read_addr_d;
      row_base_q   <= row_base_d;
      src_row_q    <= src_row_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      bl_pipe_q    <= bl_pipe_d;
      act_pipe_q   <= act_pipe_d;
    end
  end

  // Colour map: buf_pixel arrives from the buffer's output register in step with the last pipe stage.
  always_comb begin
    pixel_out = 12'h000;
    if (act_pipe_q[PIPE-1] && !bl_pipe_q[PIPE-1]) begin
      pixel_out = buf_pixel ? FG_COLOR : BG_COLOR;
    end
  end

  assign read_addr  = read_addr_q;
  assign reading    = reading_q;
  assign frame_done = frame_done_q;
  assign hsync_out  = hs_pipe_q[PIPE-1];
  assign vsync_out  = vs_pipe_q[PIPE-1];
  assign blank_out  = bl_pipe_q[PIPE-1];

endmodule
`default_nettype wire

// File: tb/tb_interlaced_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_interlaced_buffer_reader
// Purpose  : Self-checking bench for interlaced_buffer_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interlaced_buffer_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        buf_ready;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [16:0] read_addr;
  logic        reading;
  logic        buf_pixel;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic exp_reading = 1'b0;

  interlaced_buffer_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buf_ready  (buf_ready),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .read_addr  (read_addr),
    .reading    (reading),
    .buf_pixel  (buf_pixel),
    .pixel_out  (pixel_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Buffer model: pixel = address bit 0, two cycles after the address.
  logic bp_d1 = 1'b0;
  logic bp_d2 = 1'b0;
  always @(posedge clk) begin
    bp_d1 <= read_addr[0];
    bp_d2 <= bp_d1;
  end
  assign buf_pixel = bp_d2;

  typedef struct {
    int         due;
    logic [11:0] pix;
    logic       hs;
    logic       vs;
    logic       bl;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int          h;
    int          v;
    logic [16:0] addr;
  } vec_t;
  vec_t t2[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int h, input int v, input logic rd, input logic bl);
    int a;
    if (!rd || bl || h >= 640 || v >= 480) return 12'h000;
    a = (v / 2) * 320 + (h / 2);
    return (a % 2 == 1) ? 12'hFFF : 12'h000;
  endfunction

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("pixel_out", 32'(pixel_out), 32'(e.pix));
      chk("sync_blank", {29'd0, hsync_out, vsync_out, blank_out}, {29'd0, e.hs, e.vs, e.bl});
    end
  endtask

  task automatic drive(input int h, input int v, input logic hs, input logic vs,
                       input logic bl, input logic track);
    sb_t e;
    hcount   = h[10:0];
    vcount   = v[9:0];
    hsync_in = hs;
    vsync_in = vs;
    blank_in = bl;
    if (track) begin
      e.due = cyc + 3;
      e.pix = exp_pix(h, v, exp_reading, bl);
      e.hs  = hs;
      e.vs  = vs;
      e.bl  = bl;
      sb.push_back(e);
    end
    tick();
  endtask

  initial begin
    t2[0] = '{0, 0, 17'd0};
    t2[1] = '{1, 0, 17'd0};
    t2[2] = '{2, 0, 17'd1};
    t2[3] = '{0, 2, 17'd320};
    t2[4] = '{2, 2, 17'd321};

    // Reset with live-looking inputs: outputs must stay cleared.
    reset_n   = 1'b0;
    buf_ready = 1'b0;
    hcount    = 11'd700;
    vcount    = 10'd0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    blank_in  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("rst_read_addr", 32'(read_addr), 32'd0);
    chk("rst_reading", 32'(reading), 32'd0);
    chk("rst_pixel_out", 32'(pixel_out), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_syncs", {29'd0, hsync_out, vsync_out, blank_out}, 32'd0);
    reset_n = 1'b1;

    // Address sweep after arming.
    buf_ready = 1'b1;
    drive(700, 0, 0, 0, 0, 0);
    chk("arm_reading", 32'(reading), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(t2[i].h, t2[i].v, 0, 0, 0, 0);
      chk($sformatf("t2_addr%0d", i), 32'(read_addr), 32'(t2[i].addr));
      chk($sformatf("t2_reading%0d", i), 32'(reading), 32'd1);
    end

    // Walk every line to the bottom, then the last address of the frame.
    for (int v = 3; v < 480; v++) drive(0, v, 0, 0, 0, 0);
    chk("t3_row_base", 32'(read_addr), 32'd76480);
    chk("t3_fd_before", 32'(frame_done), 32'd0);
    drive(639, 479, 0, 0, 0, 0);
    chk("t3_last_addr", 32'(read_addr), 32'd76799);
    chk("t3_frame_done", 32'(frame_done), 32'd1);
    drive(700, 479, 0, 0, 0, 0);
    chk("t3_fd_pulse_end", 32'(frame_done), 32'd0);
    chk("t3_addr_hold", 32'(read_addr), 32'd76799);
    chk("t3_stay_scan", 32'(reading), 32'd1);

    // Pixel/sync alignment through the scoreboard.
    exp_reading = 1'b1;
    for (int k = 0; k < 4; k++) drive(790, 524, (k == 1), 1, 1, 1);
    for (int h = 0; h < 16; h++) drive(h, 0, (h == 5), 0, 0, 1);
    for (int h = 0; h < 8; h++) drive(h, 2, 0, (h == 3), 0, 1);
    drive(700, 2, 1, 0, 1, 1);
    drive(701, 2, 0, 0, 1, 1);
    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // buf_ready drops mid-frame: frame still completes, then idle.
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_origin_addr", 32'(read_addr), 32'd0);
    for (int v = 1; v < 480; v++) begin
      if (v == 100) buf_ready = 1'b0;
      drive(0, v, 0, 0, 0, 0);
    end
    chk("t5_still_reading", 32'(reading), 32'd1);
    chk("t5_row_base", 32'(read_addr), 32'd76480);
    drive(639, 479, 0, 0, 0, 0);
    chk("t5_last_addr", 32'(read_addr), 32'd76799);
    chk("t5_frame_done", 32'(frame_done), 32'd1);
    drive(700, 479, 0, 0, 0, 0);
    chk("t5_idle_reading", 32'(reading), 32'd0);
    chk("t5_fd_end", 32'(frame_done), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_no_rearm", 32'(reading), 32'd0);
    chk("t5_addr_hold", 32'(read_addr), 32'd76799);

    // buf_ready rises mid-frame: wait for the next origin.
    buf_ready = 1'b1;
    drive(20, 200, 0, 0, 0, 0);
    chk("t6_reading_a", 32'(reading), 32'd0);
    drive(21, 200, 0, 0, 0, 0);
    chk("t6_reading_b", 32'(reading), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_start_reading", 32'(reading), 32'd1);
    chk("t6_start_addr", 32'(read_addr), 32'd0);
    drive(2, 0, 0, 0, 0, 0);
    drive(3, 0, 0, 0, 0, 0);
    drive(4, 0, 0, 0, 0, 0);
    chk("t6_addr", 32'(read_addr), 32'd2);
    chk("t6_pixel_pre_reset", 32'(pixel_out), 32'hFFF);

    // Asynchronous reset in the middle of a frame.
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_async_reading", 32'(reading), 32'd0);
    chk("t1_async_addr", 32'(read_addr), 32'd0);
    chk("t1_async_pixel", 32'(pixel_out), 32'd0);
    tick();
    chk("t1_reading", 32'(reading), 32'd0);
    chk("t1_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_idle_first", 32'(reading), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_rearm_reading", 32'(reading), 32'd1);
    chk("t1_rearm_addr", 32'(read_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
